// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks the register file through one read port and streams {addr,data} beats over valid/ready.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      one-cycle dump request, honoured only when idle
//   abort      cancels a dump in progress without a done pulse
//   rd_addr    register file read address
//   rd_data    combinational register file read data for rd_addr
//   out_valid  out_addr/out_data hold a beat
//   out_ready  sink accepts the beat when out_valid && out_ready
//   out_addr   register index of the current beat
//   out_data   captured register value
//   freeze     core must hold register writes while high
//   busy       high in every state except IDLE
//   done       one-cycle pulse after the final beat is accepted
module reg_dump_reader #(
    parameter int PW        = 3,
    parameter int DW        = 8,
    parameter int FIRST_REG = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic [PW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    output logic          freeze,
    output logic          busy,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

    localparam logic [PW-1:0] FIRST = PW'(FIRST_REG);
    localparam logic [PW-1:0] LAST  = {PW{1'b1}};

    state_t        state, next;
    logic [PW-1:0] index;

    assign rd_addr = index;
    assign busy    = state != IDLE;
    assign freeze  = busy;

    // abort outranks everything once busy; the last index ends the dump instead of wrapping
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start ? READ : IDLE;
            READ:    next = abort ? IDLE : SEND;
            SEND:    next = abort ? IDLE : !out_ready ? SEND : index == LAST ? DONE : READ;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            index     <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            state     <= next;
            out_valid <= next == SEND;
            done      <= next == DONE;
            if (state == IDLE && start)
                index <= FIRST;
            else if (state == SEND && next == READ)
                index <= index + 1'b1;
            if (state == READ && next == SEND) begin
                out_addr <= index;
                out_data <= rd_data;
            end
        end
    end
endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: directed table-driven checks of reg_dump_reader dumps, stalls, abort, reset and FIRST_REG.
module tb_reg_dump_reader;
    typedef struct {
        logic [7:0] preload;
        logic [2:0] addr;
        logic [7:0] data;
    } vec_t;

    logic       clk = 1'b0, rst_n = 1'b1, start = 1'b0, abort = 1'b0, out_ready = 1'b1, start7 = 1'b0;
    logic [2:0] rd_addr, out_addr, rd_addr7, out_addr7;
    logic [7:0] rd_data, out_data, rd_data7, out_data7;
    logic       out_valid, freeze, busy, done, out_valid7, freeze7, busy7, done7;
    logic [7:0] regs [8];
    vec_t       tab [8];
    int         compared = 0, mismatched = 0;

    always #5 clk = ~clk;

    assign rd_data  = rd_addr == 3'd0 ? 8'h00 : regs[rd_addr];
    assign rd_data7 = rd_addr7 == 3'd0 ? 8'h00 : regs[rd_addr7];

    reg_dump_reader #(.PW(3), .DW(8), .FIRST_REG(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .freeze(freeze), .busy(busy), .done(done)
    );

    reg_dump_reader #(.PW(3), .DW(8), .FIRST_REG(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .start(start7), .abort(abort),
        .rd_addr(rd_addr7), .rd_data(rd_data7), .out_valid(out_valid7), .out_ready(out_ready),
        .out_addr(out_addr7), .out_data(out_data7), .freeze(freeze7), .busy(busy7), .done(done7)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one dump on the main instance; nc = cycle of done counted from the start cycle (0)
    task automatic do_dump(input int stall_max, input int poke, input int wr_at,
                           output int nc, output int nf, output int nb);
        int         stall;
        logic       held;
        logic [2:0] ha;
        logic [7:0] hd;
        nc = -1; nf = 0; nb = 0; stall = 0; held = 1'b0; ha = '0; hd = '0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            start = (k == poke);
            nf += int'(freeze);
            if (done) begin
                nc = k;
                break;
            end
            if (k == wr_at) check("freeze_at_write", 32'(freeze), 32'd1);
            if (held) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_addr", 32'(out_addr), 32'(ha));
                check("hold_data", 32'(out_data), 32'(hd));
            end
            if (stall > 0) begin
                out_ready = 1'b0;
                stall--;
            end else begin
                out_ready = 1'b1;
                stall = int'($urandom_range(0, stall_max));
            end
            if (out_valid && out_ready) begin
                if (nb < 8) begin
                    check("beat_addr", 32'(out_addr), 32'(tab[nb].addr));
                    check("beat_data", 32'(out_data), 32'(tab[nb].data));
                end
                nb++;
            end
            held = out_valid && !out_ready;
            ha = out_addr;
            hd = out_data;
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (nc < 0) check("dump_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int nc, nf, nb, found;
        logic saw_done;
        tab[0] = '{8'hEE, 3'd0, 8'h00};
        tab[1] = '{8'h01, 3'd1, 8'h01};
        tab[2] = '{8'h12, 3'd2, 8'h12};
        tab[3] = '{8'h13, 3'd3, 8'h13};
        tab[4] = '{8'h14, 3'd4, 8'h14};
        tab[5] = '{8'h15, 3'd5, 8'h15};
        tab[6] = '{8'h16, 3'd6, 8'h16};
        tab[7] = '{8'h17, 3'd7, 8'h17};
        for (int i = 0; i < 8; i++) regs[i] = tab[i].preload;

        #2 rst_n = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_busy_freeze_done", 32'({busy, freeze, done}), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        do_dump(0, 0, 0, nc, nf, nb);
        check("full_done_cycle", 32'(nc), 32'd17);
        check("full_freeze_cycles", 32'(nf), 32'd17);
        check("full_beats", 32'(nb), 32'd8);

        do_dump(5, 0, 0, nc, nf, nb);
        check("stall_beats", 32'(nb), 32'd8);

        // abort during SEND of beat 3
        found = 0;
        @(negedge clk) start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid && out_addr == 3'd3) begin
                found = 1;
                break;
            end
        end
        check("abort_reached_beat3", 32'(found), 32'd1);
        out_ready = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        saw_done = done;
        repeat (3) @(negedge clk) saw_done |= done;
        check("abort_no_done", 32'(saw_done), 32'd0);
        out_ready = 1'b1;
        do_dump(0, 0, 0, nc, nf, nb);
        check("post_abort_done_cycle", 32'(nc), 32'd17);
        check("post_abort_beats", 32'(nb), 32'd8);

        // asynchronous reset during READ of addr 5
        found = 0;
        @(negedge clk) start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy && !out_valid && rd_addr == 3'd5) begin
                found = 1;
                break;
            end
        end
        check("reset_reached_read5", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_out_addr", 32'(out_addr), 32'd0);
        check("async_out_data", 32'(out_data), 32'd0);
        check("async_rd_addr", 32'(rd_addr), 32'd0);
        check("async_busy_freeze_done", 32'({busy, freeze, done}), 32'd0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        check("post_reset_busy", 32'(busy), 32'd0);
        do_dump(0, 6, 0, nc, nf, nb);
        check("restart_ignored_done_cycle", 32'(nc), 32'd17);
        check("restart_ignored_beats", 32'(nb), 32'd8);

        // write to r4 requested while frozen is deferred until freeze drops
        do_dump(0, 0, 5, nc, nf, nb);
        check("frozen_dump_beats", 32'(nb), 32'd8);
        @(negedge clk);
        check("freeze_released", 32'(freeze), 32'd0);
        regs[4] = 8'h99;
        tab[4].data = 8'h99;
        do_dump(0, 0, 0, nc, nf, nb);
        check("later_dump_beats", 32'(nb), 32'd8);

        // FIRST_REG=7 single-beat dump
        regs[7] = 8'hA5;
        nc = -1;
        nb = 0;
        @(negedge clk) start7 = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start7 = 1'b0;
            if (done7) begin
                nc = k;
                break;
            end
            if (out_valid7) begin
                check("first7_addr", 32'(out_addr7), 32'd7);
                check("first7_data", 32'(out_data7), 32'hA5);
                nb++;
            end
        end
        check("first7_done_cycle", 32'(nc), 32'd3);
        check("first7_beats", 32'(nb), 32'd1);
        check("first7_busy_main_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
